// File: rtl/regfile_dumper_pkg.sv
// Shared definitions for the register-file debug dumper.
package regfile_dumper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [2:0]  HDR_PREFIX    = 3'b101;
  localparam int unsigned BYTES_PER_REG = 5;

endpackage

// File: rtl/regfile_dumper_dump_serializer.sv
// Snapshot of one register plus byte counter; emits header then data MSB first.
module regfile_dumper_dump_serializer
  import regfile_dumper_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_adv,
  input  logic [4:0]  i_idx,
  input  logic [31:0] i_data,
  output logic [7:0]  o_byte,
  output logic        o_last
);

  logic [31:0] r_snap;
  logic [2:0]  r_bcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap <= '0;
      r_bcnt <= '0;
    end else if (i_load) begin
      r_snap <= i_data;
      r_bcnt <= '0;
    end else if (i_adv) begin
      r_bcnt <= r_bcnt + 3'd1;
    end
  end

  always_comb begin
    o_byte = '0;
    case (r_bcnt)
      3'd0:    o_byte = {HDR_PREFIX, i_idx};
      3'd1:    o_byte = r_snap[31:24];
      3'd2:    o_byte = r_snap[23:16];
      3'd3:    o_byte = r_snap[15:8];
      3'd4:    o_byte = r_snap[7:0];
      default: o_byte = '0;
    endcase
  end

  assign o_last = (r_bcnt == 3'(BYTES_PER_REG - 1));

endmodule

// File: rtl/regfile_dumper.sv
// Walks FIRST_REG..LAST_REG through a borrowed read port and streams each
// register as a 5-byte record over valid/ready.
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_done,
  output logic [4:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [7:0]  o_out_byte
);

  if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
    $error("regfile_dumper: require FIRST_REG <= LAST_REG <= 31");
  end

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  state_t     r_state, w_next;
  logic [4:0] r_idx, w_idx_next;
  logic       w_hs, w_last;
  logic [7:0] w_byte;

  assign w_hs = (r_state == ST_SEND) && i_out_ready;

  // Terminal check happens before the increment, so idx never wraps at 31.
  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    case (r_state)
      ST_IDLE: if (i_start) begin
        w_next     = ST_LOAD;
        w_idx_next = FIRST_IDX;
      end
      ST_LOAD: w_next = ST_SEND;
      ST_SEND: if (w_hs && w_last) begin
        if (r_idx == LAST_IDX) begin
          w_next = ST_DONE;
        end else begin
          w_next     = ST_LOAD;
          w_idx_next = r_idx + 5'd1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (i_abort) begin
      w_next     = ST_IDLE;
      w_idx_next = r_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
    end
  end

  regfile_dumper_dump_serializer u_ser (
    .clk    (clk),
    .reset  (reset),
    .i_load (r_state == ST_LOAD),
    .i_adv  (w_hs),
    .i_idx  (r_idx),
    .i_data (i_rd_data),
    .o_byte (w_byte),
    .o_last (w_last)
  );

  assign o_busy      = (r_state == ST_LOAD) || (r_state == ST_SEND);
  assign o_done      = (r_state == ST_DONE);
  assign o_rd_addr   = r_idx;
  assign o_out_valid = (r_state == ST_SEND);
  assign o_out_byte  = o_out_valid ? w_byte : '0;

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench for regfile_dumper: table vectors, random dumps against
// a queue-based reference model, and hand-written abort/reset/bypass sequences.
module tb_regfile_dumper;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, out_ready;
  logic        busy, done, out_valid;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  out_byte;

  logic        start2, abort2, ready2;
  logic        busy2, done2, valid2;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data2;
  logic [7:0]  byte2;

  logic [31:0] rf [32];
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int   checks = 0, errors = 0;
  int   cyc = 0, done_cnt = 0, done_cnt2 = 0, busy_cnt = 0, done_cyc = 0;
  logic [7:0] cap[$], cap2[$], exp_q[$];
  logic       prev_stall = 1'b0, prev_abort = 1'b0;
  logic [7:0] prev_byte = '0;

  always #5 clk = ~clk;

  regfile_dumper dut (
    .clk(clk), .reset(reset), .i_start(start), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_byte(out_byte)
  );

  regfile_dumper #(.FIRST_REG(31), .LAST_REG(31)) dut2 (
    .clk(clk), .reset(reset), .i_start(start2), .i_abort(abort2),
    .o_busy(busy2), .o_done(done2), .o_rd_addr(rd_addr2), .i_rd_data(rd_data2),
    .o_out_valid(valid2), .i_out_ready(ready2), .o_out_byte(byte2)
  );

  // Register file model: R0 reads zero, pending write bypasses to the read port.
  always_comb begin
    rd_data = (rd_addr == 5'd0) ? 32'd0 : rf[rd_addr];
    if (wr_en && wr_addr == rd_addr && rd_addr != 5'd0) rd_data = wr_data;
    rd_data2 = (rd_addr2 == 5'd0) ? 32'd0 : rf[rd_addr2];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_abort) begin
        chk("stall_valid_hold", {63'd0, out_valid}, 64'd1);
        chk("stall_byte_hold", {56'd0, out_byte}, {56'd0, prev_byte});
      end
      if (out_valid && out_ready) cap.push_back(out_byte);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
      if (valid2) cap2.push_back(byte2);
      if (done2) done_cnt2++;
      prev_stall = out_valid && !out_ready;
      prev_byte  = out_byte;
      prev_abort = abort;
    end
  end

  // Reference: each register in range yields header {101,idx} then its value MSB first.
  task automatic make_exp(input int first, input int last);
    logic [31:0] v;
    exp_q.delete();
    for (int r = first; r <= last; r++) begin
      v = (r == 0) ? 32'd0 : rf[r];
      exp_q.push_back({3'b101, 5'(r)});
      for (int b = 3; b >= 0; b--) exp_q.push_back(v[8*b +: 8]);
    end
  endtask

  task automatic cmp_stream(input string name);
    chk({name, "_len"}, 64'(cap.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) chk(name, {56'd0, cap[i]}, {56'd0, exp_q[i]});
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_busy"}, {63'd0, busy}, 64'd0);
    chk({name, "_done"}, {63'd0, done}, 64'd0);
    chk({name, "_valid"}, {63'd0, out_valid}, 64'd0);
    chk({name, "_byte"}, {56'd0, out_byte}, 64'd0);
    chk({name, "_addr"}, {59'd0, rd_addr}, 64'd0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_done(input bit rnd_ready, input bit inj, input bit extra, input int budget);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      if (wr_en) rf[wr_addr] = wr_data;
      #1;
      n++;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = extra && busy && ($urandom_range(0, 3) == 0);
      wr_en     = 1'b0;
      if (inj && busy && rd_addr == 5'd8) begin
        wr_en   = 1'b1;
        wr_addr = 5'd8;
        wr_data = out_valid ? 32'h1111_1111 : 32'hDEAD_BEEF;
      end
    end
    chk("dump_completes", {63'd0, done_cnt != d0}, 64'd1);
    out_ready = 1'b1;
    start     = 1'b0;
    wr_en     = 1'b0;
  endtask

  typedef struct {
    int          regno;
    logic [31:0] val;
    logic [39:0] rec;
  } vec_t;

  vec_t tbl[4];
  logic [7:0] exp31[5];

  initial begin
    int start_cyc, d0, n;
    logic [39:0] rec;

    tbl[0] = '{regno: 29, val: 32'h7fff_fffc, rec: 40'hBD_7F_FF_FF_FC};
    tbl[1] = '{regno: 0,  val: 32'h0,         rec: 40'hA0_00_00_00_00};
    tbl[2] = '{regno: 1,  val: 32'h0,         rec: 40'hA1_00_00_00_00};
    tbl[3] = '{regno: 31, val: 32'h0,         rec: 40'hBF_00_00_00_00};
    exp31  = '{8'hBF, 8'h12, 8'h34, 8'h56, 8'h78};

    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk); @(negedge clk); #1;
    reset = 1'b1;

    // Table-driven default dump with out_ready held high.
    foreach (tbl[i]) rf[tbl[i].regno] = tbl[i].val;
    make_exp(0, 31);
    cap.delete(); busy_cnt = 0; d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("lat_load_busy", {63'd0, busy}, 64'd1);
    chk("lat_load_valid", {63'd0, out_valid}, 64'd0);
    chk("lat_load_addr", {59'd0, rd_addr}, 64'd0);
    @(posedge clk); #1;
    chk("lat_hdr_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_hdr_byte", {56'd0, out_byte}, 64'hA0);
    run_to_done(1'b0, 1'b0, 1'b0, 400);
    chk("dflt_done_once", 64'(done_cnt - d0), 64'd1);
    chk("dflt_busy_cycles", 64'(busy_cnt), 64'd192);
    chk("dflt_done_latency", 64'(done_cyc - start_cyc), 64'd193);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    foreach (tbl[i]) begin
      for (int k = 0; k < 5; k++) rec[8*(4-k) +: 8] = cap[5*tbl[i].regno + k];
      chk($sformatf("tbl_rec_r%0d", tbl[i].regno), {24'd0, rec}, {24'd0, tbl[i].rec});
    end
    cmp_stream("dflt_stream");

    // Random register contents, random backpressure.
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    make_exp(0, 31);
    cap.delete(); d0 = done_cnt;
    pulse_start();
    run_to_done(1'b1, 1'b0, 1'b0, 3000);
    chk("rnd_done_once", 64'(done_cnt - d0), 64'd1);
    cmp_stream("rnd_stream");

    // Start pulses while busy must not restart or duplicate.
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    make_exp(0, 31);
    cap.delete(); d0 = done_cnt;
    pulse_start();
    run_to_done(1'b0, 1'b0, 1'b1, 400);
    chk("restart_done_once", 64'(done_cnt - d0), 64'd1);
    cmp_stream("restart_stream");

    // Single-register instance at the top index.
    rf[31] = 32'h1234_5678;
    cap2.delete(); d0 = done_cnt2;
    @(posedge clk); #1; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    n = 0;
    while (done_cnt2 == d0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("r31_done_once", 64'(done_cnt2 - d0), 64'd1);
    chk("r31_len", 64'(cap2.size()), 64'd5);
    for (int k = 0; k < 5; k++) chk("r31_byte", {56'd0, cap2[k]}, {56'd0, exp31[k]});

    // Same-cycle write bypass during LOAD of R8, then writes during its SEND.
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    make_exp(0, 31);
    exp_q[41] = 8'hDE; exp_q[42] = 8'hAD; exp_q[43] = 8'hBE; exp_q[44] = 8'hEF;
    cap.delete(); d0 = done_cnt;
    pulse_start();
    run_to_done(1'b1, 1'b1, 1'b0, 3000);
    cmp_stream("bypass_stream");

    // Start and abort together in IDLE: abort wins.
    @(posedge clk); #1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {63'd0, busy}, 64'd0);

    // Abort mid register 5, then a fresh dump.
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    make_exp(0, 31);
    cap.delete(); d0 = done_cnt;
    pulse_start();
    n = 0;
    while (!(out_valid && rd_addr == 5'd5 && cap.size() >= 27) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("abort_reached_r5", {63'd0, n < 300}, 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid_low", {63'd0, out_valid}, 64'd0);
    chk("abort_busy_low", {63'd0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    cap.delete();
    pulse_start();
    run_to_done(1'b1, 1'b0, 1'b0, 3000);
    chk("post_abort_hdr", {56'd0, cap[0]}, 64'hA0);
    chk("post_abort_done", 64'(done_cnt - d0), 64'd1);
    cmp_stream("post_abort_stream");

    // Asynchronous reset mid-dump.
    d0 = done_cnt;
    pulse_start();
    repeat (40) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_no_done", 64'(done_cnt - d0), 64'd0);
    chk("midreset_idle", {63'd0, busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Debug read-side engine for the CPU register file. On a start pulse it walks register addresses FIRST_REG..LAST_REG through one register-file read port, snapshots each 32-bit value, and emits it as a byte stream over a valid/ready interface. The stream feeds the UART transmitter, which turns it into a host-side register dump. It sits beside the datapath and borrows a read port while the CPU is halted.

## Interface
- FIRST_REG, default 0: first register index dumped (0..31).
- LAST_REG, default 31: last register index dumped (FIRST_REG..31).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle request to begin a dump; honoured only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE on the next edge from any state.
- busy  out  1  high in LOAD and SEND.
- done  out  1  one-cycle pulse after the last byte of the dump is accepted.
- rd_addr  out  5  register-file read address; equals the current register index.
- rd_data  in  32  register-file read data; combinational with rd_addr; register 0 reads 0.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  consumer accepts out_byte when out_valid & out_ready at a rising edge.
- out_byte  out  8  stream byte.

## Operation
- States: IDLE, LOAD, SEND, DONE.
- IDLE: start=1 loads idx <= FIRST_REG, next state LOAD.
- LOAD (one cycle): rd_addr=idx; the edge captures rd_data into a 32-bit snapshot register, clears byte counter bcnt, next state SEND.
- SEND: out_valid=1. Per register, 5 bytes in order:
  - header {3'b101, idx}
  - data[31:24], data[23:16], data[15:8], data[7:0]
- Each handshake increments bcnt. On the handshake with bcnt=4:
  - if idx==LAST_REG, next state DONE;
  - else idx <= idx+1, next state LOAD.
- DONE: done=1 for one cycle, then IDLE.
- abort has priority over every other transition. It forces IDLE, drops out_valid next cycle, and does not pulse done.
- start outside IDLE is ignored. start and abort together in IDLE: abort wins, so the block stays in IDLE.
- Snapshot semantics: the value dumped is rd_data during that register's LOAD cycle, including any same-cycle write bypass from the register file. Later writes do not change bytes already snapshotted.
- idx never wraps. The LAST_REG=31 terminal check must precede any increment, so no 5-bit overflow occurs.
- Stream rule: while out_valid=1 and out_ready=0, out_byte holds stable. out_valid never drops without a handshake except on abort or reset.

## Timing
- Reset values: state IDLE; busy, done and out_valid 0; out_byte 0; rd_addr 0; snapshot 0; bcnt 0.
- Reset asserted mid-dump: immediate return to reset values; no done pulse.
- start sampled at edge N: LOAD during cycle N+1 (busy=1); first header valid during cycle N+2.
- With out_ready held at 1, each register takes 6 cycles (1 LOAD + 5 SEND).
- Full default dump: 192 busy cycles, then a done pulse in the following cycle.
- Backpressure adds cycles only in SEND. LOAD never waits on out_ready.
- rd_addr is registered (driven from idx) and stable throughout LOAD and SEND.

## Structure
- Shared debug package holds:
  - the state enum (IDLE/LOAD/SEND/DONE);
  - HDR_PREFIX = 3'b101;
  - BYTES_PER_REG = 5.
- An elaboration-time check requires FIRST_REG <= LAST_REG <= 31.
- One sub-module is natural: dump_serializer. It holds the snapshot, bcnt and the byte mux, loads on LOAD, and advances on handshake. The top level keeps the FSM and idx.

## Test plan
- Default parameters, out_ready=1, R29=0x7ffffffc, all others 0, start pulse -> 160 bytes. Register 29's record is A0? no: header 0xBD then 7F FF FF FC. Register 0's record is A0 00 00 00 00. done pulses exactly once, 193 cycles after start.
- out_ready toggled pseudo-randomly -> same byte sequence; out_byte stable whenever out_valid & !out_ready.
- FIRST_REG=LAST_REG=31, R31=0x12345678 -> bytes BF 12 34 56 78, then done.
- Write R8=0xDEADBEEF in the same cycle as LOAD of register 8 -> dumped data DE AD BE EF. A write to R8 during its SEND bytes does not alter the remaining bytes.
- abort asserted mid-register 5, then start again -> out_valid low the next cycle, no done pulse, new dump restarts at header 0xA0.
- reset deasserted-to-asserted mid-dump, plus start pulsed while busy -> all outputs at reset values immediately; start while busy does not restart or duplicate bytes.
